mag_frame_scheduler: RTL

MAG_FRAME_SCHEDULER -- requirements
Module: mag_frame_scheduler

---
 rtl/mag_frame_scheduler_pkg.sv | 39 +++
 rtl/sample_fifo.sv | 56 +++++
 rtl/mag_frame_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mag_frame_scheduler_pkg.sv
// Shared constants, level encoding, FSM states and the level threshold rule.
package mag_frame_scheduler_pkg;

  localparam int NBINS = 16;
  localparam int MAG_W = 16;

  localparam logic [1:0] LVL_NONE = 2'd0;
  localparam logic [1:0] LVL_LOW  = 2'd1;
  localparam logic [1:0] LVL_MID  = 2'd2;
  localparam logic [1:0] LVL_HIGH = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ACCUM   = 3'd3,
    ST_PUBLISH = 3'd4
  } state_t;

  // Quantise a bin peak against the frame maximum. Thresholds are widened
  // to 18 bits so (max>>2)*3 never loses its top bits.
  function automatic logic [1:0] level_of(input logic [MAG_W-1:0] peak,
                                          input logic [MAG_W-1:0] fmax);
    logic [17:0] pk;
    logic [17:0] t1;
    logic [17:0] t2;
    logic [17:0] t3;
    pk = {2'b00, peak};
    t1 = {4'b0000, fmax[MAG_W-1:2]};
    t2 = {3'b000, fmax[MAG_W-1:1]};
    t3 = t1 * 18'd3;
    if (fmax == '0)    level_of = LVL_NONE;
    else if (pk >= t3) level_of = LVL_HIGH;
    else if (pk >= t2) level_of = LVL_MID;
    else if (pk >= t1) level_of = LVL_LOW;
    else               level_of = LVL_NONE;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO for buffered FFT bin samples.
// Handshake: push is taken only when !full, pop only when !empty; a push on
// a full FIFO is refused even if a pop happens in the same cycle.
module sample_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk_cal,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_cal) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk_cal) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mag_frame_scheduler.sv
// Buffers FFT bin samples, asks a CORDIC core for each magnitude, tracks
// per-bin peaks over FRAMES frames and publishes a 2-bit level per bin.
// Input handshake: a sample moves when in_valid && in_ready in the same cycle.
// CORDIC handshake: cordic_req stays high with stable operands until a
// cordic_done pulse; cordic_done at any other time is ignored.
module mag_frame_scheduler
  import mag_frame_scheduler_pkg::*;
#(
  parameter int FRAMES     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_cal,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_bin,
  input  logic        in_last,
  output logic        cordic_req,
  output logic [15:0] cordic_x,
  output logic [15:0] cordic_y,
  input  logic        cordic_done,
  input  logic [15:0] cordic_mag,
  output logic [31:0] level_data,
  output logic        level_valid,
  output logic [2:0]  dbg_state
);

  localparam int EW = 32 + 4 + 1;

  state_t             state_q;
  state_t             state_d;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [EW-1:0]      fifo_dout;
  logic [3:0]         w_bin;
  logic               w_last;
  logic [MAG_W-1:0]   mag_q;
  logic [MAG_W-1:0]   peak [NBINS];
  logic [MAG_W-1:0]   frame_max;
  logic [3:0]         frame_cnt;
  logic [3:0]         frame_cnt_inc;
  logic [2*NBINS-1:0] levels_d;

  assign in_ready      = !fifo_full;
  assign frame_cnt_inc = frame_cnt + 4'd1;
  assign dbg_state     = state_q;

  sample_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_cal (clk_cal),
    .rst     (rst),
    .push    (in_valid),
    .pop     (fifo_pop),
    .din     ({in_data, in_bin, in_last}),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk_cal) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state, FIFO pop and CORDIC request decode.
  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    cordic_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cordic_req = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        cordic_req = 1'b1;
        if (cordic_done) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (w_last && (frame_cnt_inc == 4'(FRAMES))) state_d = ST_PUBLISH;
        else                                         state_d = ST_IDLE;
      end
      ST_PUBLISH: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Level of every bin from the current peaks and frame maximum.
  always_comb begin
    levels_d = '0;
    for (int b = 0; b < NBINS; b++) begin
      levels_d[2*b +: 2] = level_of(peak[b], frame_max);
    end
  end

  // Working register, peak accumulation and publish datapath.
  always_ff @(posedge clk_cal) begin
    if (rst) begin
      cordic_x    <= '0;
      cordic_y    <= '0;
      w_bin       <= '0;
      w_last      <= 1'b0;
      mag_q       <= '0;
      frame_max   <= '0;
      frame_cnt   <= '0;
      level_data  <= '0;
      level_valid <= 1'b0;
      for (int b = 0; b < NBINS; b++) peak[b] <= '0;
    end else begin
      level_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cordic_x <= fifo_dout[36:21];
            cordic_y <= fifo_dout[20:5];
            w_bin    <= fifo_dout[4:1];
            w_last   <= fifo_dout[0];
          end
        end
        ST_WAIT: begin
          if (cordic_done) mag_q <= cordic_mag;
        end
        ST_ACCUM: begin
          if (mag_q > peak[w_bin]) peak[w_bin] <= mag_q;
          if (mag_q > frame_max)   frame_max   <= mag_q;
          if (w_last)              frame_cnt   <= frame_cnt_inc;
        end
        ST_PUBLISH: begin
          level_data  <= levels_d;
          level_valid <= 1'b1;
          frame_max   <= '0;
          frame_cnt   <= '0;
          for (int b = 0; b < NBINS; b++) peak[b] <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
